// File: rtl/uart_tx_stream.sv
// UART transmitter sink: accepts a word over valid/ready while idle and shifts it
// out as one start bit, DATA_SIZE data bits (LSB first) and one stop bit.
module uart_tx_stream #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_SIZE + 1);

    localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BCNT_ONE  = BW'(1);
    localparam logic [IW-1:0] BIDX_LAST = IW'(DATA_SIZE - 1);
    localparam logic [IW-1:0] BIDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [IW-1:0]        bidx_q, bidx_d;
    logic [DATA_SIZE-1:0] sreg_q, sreg_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 accept_s;
    logic                 bit_end_s;

    // Ready depends only on registered state, so upstream valid never loops back here.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign accept_s  = in_valid && in_ready;
    assign bit_end_s = (bcnt_q == BCNT_LAST);

    assign tx   = tx_q;
    assign busy = busy_q;

    // Next-state, counter and shift-register logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bidx_d  = bidx_q;
        sreg_d  = sreg_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = START;
                    sreg_d  = in_data;
                    bcnt_d  = '0;
                    bidx_d  = '0;
                end else begin
                    bcnt_d  = '0;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                    bidx_d  = '0;
                end else begin
                    bcnt_d  = bcnt_q + BCNT_ONE;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    bcnt_d = '0;
                    sreg_d = sreg_q >> 1;
                    bidx_d = bidx_q + BIDX_ONE;
                    if (bidx_q == BIDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    bcnt_d = bcnt_q + BCNT_ONE;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                end else begin
                    bcnt_d  = bcnt_q + BCNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
                bidx_d  = '0;
            end
        endcase
    end

    // Line level is computed from the next state so the registered tx lines up with it.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset aborts any frame and drops the latched word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            sreg_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            sreg_q  <= sreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

`ifdef FORMAL
    localparam int FRAME_CLKS = (DATA_SIZE + 2) * CLKS_PER_BIT;

    a_tx_high: assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE || state_q == STOP) |-> tx_q);
    a_tx_low: assert property (@(posedge clk) disable iff (reset)
        (state_q == START) |-> !tx_q);
    a_ready_idle: assert property (@(posedge clk) in_ready |-> !busy_q);
    a_bcnt_range: assert property (@(posedge clk) int'(bcnt_q) < CLKS_PER_BIT);
    a_bidx_range: assert property (@(posedge clk) int'(bidx_q) <= DATA_SIZE);
    c_back_to_back: cover property (@(posedge clk) disable iff (reset)
        accept_s ##1 busy_q [*FRAME_CLKS] ##1 accept_s);
`endif

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench: handshakes push the sent word, a line monitor decodes each
// frame, checks its waveform/length and compares against the queued word.
module tb_uart_tx_stream;
    localparam int CPB_A = 4;
    localparam int CPB_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, val_a, rdy_a, tx_a, busy_a;
    logic [7:0] dat_a;
    logic       rst_b, val_b, rdy_b, tx_b, busy_b;
    logic [7:0] dat_b;

    uart_tx_stream #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB_A)) dut_a (
        .clk(clk), .reset(rst_a), .in_valid(val_a), .in_data(dat_a),
        .in_ready(rdy_a), .tx(tx_a), .busy(busy_a)
    );
    uart_tx_stream #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB_B)) dut_b (
        .clk(clk), .reset(rst_b), .in_valid(val_b), .in_data(dat_b),
        .in_ready(rdy_b), .tx(tx_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] expq_a[$];
    logic [7:0] expq_b[$];
    int         starts_a[$];
    int         cnt [2];
    bit         inf [2];
    logic [7:0] cur [2];
    int         bad [2];
    int         done [2];
    int         hs [2];
    logic       obs [2][64];
    logic [9:0] lastbits [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int m, input int cpb, input logic rst,
                            input logic txv, input logic bsy, input logic rdy);
        int f;
        int mism;
        f = 10 * cpb;
        if (rst) begin
            inf[m] = 1'b0;
            return;
        end
        if (!inf[m] && txv === 1'b0) begin
            inf[m] = 1'b1;
            cnt[m] = 0;
            bad[m] = 0;
            if (m == 0) starts_a.push_back(cyc);
            if (m == 0 && expq_a.size() > 0) cur[m] = expq_a.pop_front();
            else if (m == 1 && expq_b.size() > 0) cur[m] = expq_b.pop_front();
            else check("unexpected frame", 32'd1, 32'd0);
        end
        if (inf[m]) begin
            if (cnt[m] < f) begin
                obs[m][cnt[m]] = txv;
                if (bsy !== 1'b1 || rdy !== 1'b0) bad[m]++;
                cnt[m]++;
            end else begin
                check("idle after frame", {30'd0, txv, bsy}, 32'd2);
                for (int k = 0; k < 10; k++) lastbits[m][k] = obs[m][k * cpb + cpb / 2];
                mism = 0;
                for (int c = 0; c < f; c++)
                    if (obs[m][c] !== lastbits[m][c / cpb]) mism++;
                check("frame shape", bad[m] + mism, 32'd0);
                check("frame data", {24'd0, lastbits[m][8:1]}, {24'd0, cur[m]});
                inf[m] = 1'b0;
                done[m]++;
            end
        end
    endtask

    // Handshake recorder and line monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_a && val_a && rdy_a) begin
            expq_a.push_back(dat_a);
            hs[0]++;
            check("hs only idle a", {31'd0, busy_a}, 32'd0);
        end
        if (!rst_b && val_b && rdy_b) begin
            expq_b.push_back(dat_b);
            hs[1]++;
            check("hs only idle b", {31'd0, busy_b}, 32'd0);
        end
        mon_step(0, CPB_A, rst_a, tx_a, busy_a, rdy_a);
        mon_step(1, CPB_B, rst_b, tx_b, busy_b, rdy_b);
    end

    // Called at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic send(input int m, input logic [7:0] w);
        int t;
        t = 0;
        if (m == 0) begin val_a = 1'b1; dat_a = w; end
        else begin val_b = 1'b1; dat_b = w; end
        @(negedge clk);
        while (((m == 0) ? rdy_a : rdy_b) !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("handshake timeout", t < 200, 32'd1);
        @(posedge clk);
        #1;
        if (m == 0) begin val_a = 1'b0; dat_a = 8'h00; end
        else begin val_b = 1'b0; dat_b = 8'h00; end
    endtask

    task automatic wait_frames(input int m, input int n);
        int t;
        t = 0;
        while (done[m] < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("frame timeout", done[m] >= n, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, h0, idle_bad;
        for (int m = 0; m < 2; m++) begin
            cnt[m] = 0; inf[m] = 1'b0; bad[m] = 0; done[m] = 0; hs[m] = 0;
        end
        rst_a = 1'b1; val_a = 1'b0; dat_a = 8'h00;
        rst_b = 1'b1; val_b = 1'b0; dat_b = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready low", {31'd0, rdy_a}, 32'd0);
        check("reset tx/busy", {30'd0, tx_a, busy_a}, 32'd2);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;

        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b1) idle_bad++;
        end
        check("idle 20 cycles", idle_bad, 32'd0);

        // Single 0xA5 frame
        @(posedge clk); #1;
        d0 = done[0]; h0 = hs[0];
        send(0, 8'hA5);
        wait_frames(0, d0 + 1);
        check("a5 bit pattern", {22'd0, lastbits[0]}, {22'd0, 10'b1101001010});
        check("a5 handshakes", hs[0] - h0, 32'd1);

        // Three queued words, back to back
        @(posedge clk); #1;
        d0 = done[0]; starts_a.delete();
        send(0, 8'h01);
        send(0, 8'h02);
        send(0, 8'h03);
        wait_frames(0, d0 + 3);
        check("b2b frame count", starts_a.size(), 32'd3);
        if (starts_a.size() == 3) begin
            check("b2b spacing 1", starts_a[1] - starts_a[0], 32'd41);
            check("b2b spacing 2", starts_a[2] - starts_a[1], 32'd41);
        end

        // Toggling valid/data during a frame must be ignored
        @(posedge clk); #1;
        d0 = done[0]; h0 = hs[0];
        send(0, 8'h3C);
        for (int i = 0; i < 30; i++) begin
            val_a = (i % 2 == 0);
            dat_a = (i % 2 == 0) ? 8'hFF : 8'h00;
            @(posedge clk); #1;
        end
        val_a = 1'b0; dat_a = 8'h00;
        wait_frames(0, d0 + 1);
        check("toggle handshakes", hs[0] - h0, 32'd1);

        // Reset at cycle 15 of a frame, then a clean frame
        @(posedge clk); #1;
        d0 = done[0];
        send(0, 8'h77);
        repeat (15) @(posedge clk);
        #1 rst_a = 1'b1;
        @(negedge clk);
        check("mid reset ready low", {31'd0, rdy_a}, 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        check("abort tx/busy/ready", {29'd0, tx_a, busy_a, rdy_a}, 32'd5);
        check("aborted frame not done", done[0] - d0, 32'd0);
        @(posedge clk); #1;
        send(0, 8'h5A);
        wait_frames(0, d0 + 1);
        check("5a bit pattern", {22'd0, lastbits[0]}, {22'd0, 10'b1010110100});

        // Three clocks per bit
        @(posedge clk); #1;
        send(1, 8'h81);
        wait_frames(1, 1);
        check("81 bit pattern", {22'd0, lastbits[1]}, {22'd0, 10'b1100000010});
        check("81 handshakes", hs[1], 32'd1);

        repeat (5) @(negedge clk);
        check("scoreboard empty", expq_a.size() + expq_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
